// File: rtl/conv_tap_sequencer.sv
// Latches one 3x3 window of pixels and replays it one tap per handshake,
// pairing each pixel with its coefficient select for the LUT/MAC stage.
// Ports:
//   in_clk, in_rst               clock, synchronous active-high reset
//   in_win_valid / ou_win_ready  window handshake, in_win_data = 9 taps
//   ou_tap_valid / in_tap_ready  tap handshake
//   ou_LUT_select, ou_tap_pixel  current tap index and pixel
//   ou_tap_first, ou_tap_last    tap index is 0 / NUM_TAPS-1
//   ou_busy                      a window is held
//   ou_win_done                  one-cycle pulse after the last tap
//   ou_win_count                 completed windows (wrapping)
module conv_tap_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NUM_TAPS = 9,
  parameter int SEL_W    = 4,
  parameter int COUNT_W  = 16
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_win_valid,
  output logic                       ou_win_ready,
  input  logic [DATA_W*NUM_TAPS-1:0] in_win_data,
  output logic [SEL_W-1:0]           ou_LUT_select,
  output logic [DATA_W-1:0]          ou_tap_pixel,
  output logic                       ou_tap_valid,
  input  logic                       in_tap_ready,
  output logic                       ou_tap_first,
  output logic                       ou_tap_last,
  output logic                       ou_busy,
  output logic                       ou_win_done,
  output logic [COUNT_W-1:0]         ou_win_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(NUM_TAPS - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  win_q [NUM_TAPS];
  logic [DATA_W-1:0]  win_d [NUM_TAPS];

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  // The count is bumped on the final transfer so that it is
  // already updated while ou_win_done is high.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    unique case (state_q)
      S_IDLE: begin
        sel_d = '0;
        if (in_win_valid) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            win_d[k] = in_win_data[k*DATA_W +: DATA_W];
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_tap_ready) begin
          if (sel_q == LastSel) begin
            sel_d   = '0;
            cnt_d   = cnt_q + COUNT_W'(1);
            state_d = S_DONE;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ou_win_ready = 1'b0;
    ou_tap_valid = 1'b0;
    ou_busy      = 1'b0;
    ou_win_done  = 1'b0;
    unique case (state_q)
      S_IDLE: ou_win_ready = 1'b1;
      S_RUN: begin
        ou_tap_valid = 1'b1;
        ou_busy      = 1'b1;
      end
      S_DONE: begin
        ou_win_done = 1'b1;
        ou_busy     = 1'b1;
      end
      default: ou_win_ready = 1'b0;
    endcase
  end

  assign ou_LUT_select = sel_q;
  assign ou_tap_pixel  = win_q[sel_q];
  assign ou_tap_first  = ou_tap_valid && (sel_q == '0);
  assign ou_tap_last   = ou_tap_valid && (sel_q == LastSel);
  assign ou_win_count  = cnt_q;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Bench for conv_tap_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a window-level model.
module tb_conv_tap_sequencer;

  localparam int DW = 32;
  localparam int NT = 9;
  localparam int CW = 2;
  localparam int WB = DW * NT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          win_valid = 1'b0;
  logic          win_ready;
  logic [WB-1:0] win_data = '0;
  logic [3:0]    sel;
  logic [DW-1:0] pixel;
  logic          tap_valid;
  logic          tap_ready = 1'b0;
  logic          first, last, busy, done;
  logic [CW-1:0] count;

  int ntot = 0;
  int npass = 0;

  always #5 clk = ~clk;

  conv_tap_sequencer #(
    .DATA_W(DW), .NUM_TAPS(NT), .SEL_W(4), .COUNT_W(CW)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .in_win_valid(win_valid),
    .ou_win_ready(win_ready),
    .in_win_data(win_data),
    .ou_LUT_select(sel),
    .ou_tap_pixel(pixel),
    .ou_tap_valid(tap_valid),
    .in_tap_ready(tap_ready),
    .ou_tap_first(first),
    .ou_tap_last(last),
    .ou_busy(busy),
    .ou_win_done(done),
    .ou_win_count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Window-level model: a held window, the index of the next tap
  // to hand out, and a pending-done flag for the cycle after it.
  bit          chk_en = 0;
  bit          m_held = 0;
  bit          m_done = 0;
  int          m_pos = 0;
  int          m_cnt = 0;
  logic [31:0] m_win [NT];

  always @(posedge clk) begin
    if (rst) begin
      m_held = 0; m_done = 0; m_pos = 0; m_cnt = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_held) begin
      if (win_valid) begin
        for (int k = 0; k < NT; k++) m_win[k] = win_data[k*DW +: DW];
        m_held = 1;
        m_pos = 0;
      end
    end else if (tap_ready) begin
      m_pos++;
      if (m_pos == NT) begin
        m_held = 0;
        m_pos = 0;
        m_done = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", win_ready, !m_held && !m_done);
      chk("m_valid", tap_valid, m_held);
      chk("m_busy", busy, m_held || m_done);
      chk("m_done", done, m_done);
      chk("m_count", count, m_cnt);
      chk("m_sel", sel, m_held ? m_pos : 0);
      if (m_held) begin
        chk("m_pixel", pixel, m_win[m_pos]);
        chk("m_first", first, m_pos == 0);
        chk("m_last", last, m_pos == NT - 1);
      end
    end
  end

  function automatic logic [WB-1:0] mkwin(input logic [31:0] base,
                                          input bit inc);
    logic [WB-1:0] w;
    for (int k = 0; k < NT; k++)
      w[k*DW +: DW] = inc ? (base | 32'(k)) : base;
    return w;
  endfunction

  // Starts #1 after a rising edge in IDLE; returns likewise.
  task automatic run_window(input logic [WB-1:0] d,
                            input logic [WB-1:0] nd,
                            input bit hold, input int ssel,
                            input int sn, input int ecnt,
                            input string tg);
    int es, st;
    logic [31:0] ep;
    win_valid = 1; win_data = d; tap_ready = 1;
    @(negedge clk);
    chk({tg, "_idle_ready"}, win_ready, 1);
    @(posedge clk); #1;
    win_data = nd; win_valid = hold;
    es = 0; st = 0;
    while (es < NT) begin
      @(negedge clk);
      ep = d[es*DW +: DW];
      chk({tg, "_ready"}, win_ready, 0);
      chk({tg, "_valid"}, tap_valid, 1);
      chk({tg, "_sel"}, sel, es);
      chk({tg, "_pixel"}, pixel, ep);
      chk({tg, "_first"}, first, es == 0);
      chk({tg, "_last"}, last, es == NT - 1);
      chk({tg, "_nodone"}, done, 0);
      tap_ready = !(es == ssel && st < sn);
      if (tap_ready) es++;
      else st++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tg, "_done"}, done, 1);
    chk({tg, "_done_valid"}, tap_valid, 0);
    chk({tg, "_done_ready"}, win_ready, 0);
    chk({tg, "_count"}, count, ecnt);
    @(posedge clk); #1;
  endtask

  logic [WB-1:0] wa, wb, wc;
  int wrap_exp [5] = '{1, 2, 3, 0, 1};

  initial begin
    wa = mkwin(32'h40000000, 1);
    wb = mkwin(32'hBF800000, 0);
    wc = mkwin(32'h3F800000, 1);

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", win_ready, 1);
    chk("rst_valid", tap_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_sel", sel, 0);
    @(posedge clk); #1;

    run_window(wa, wa, 0, -1, 0, 1, "basic");
    run_window(wa, wa, 0, 4, 3, 2, "stall");
    run_window(wc, wb, 1, -1, 0, 3, "b2b_a");
    run_window(wb, wb, 0, -1, 0, 0, "b2b_b");

    win_valid = 1; win_data = wa; tap_ready = 1;
    @(posedge clk); #1;
    win_valid = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_sel5", sel, 5);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid_valid", tap_valid, 0);
    chk("mid_sel", sel, 0);
    chk("mid_ready", win_ready, 1);
    chk("mid_done", done, 0);
    chk("mid_count", count, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      run_window(wc, wc, 0, i, i, wrap_exp[i], "wrap");

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      win_valid = ($urandom % 3) != 0;
      for (int k = 0; k < NT; k++) win_data[k*DW +: DW] = $urandom;
      tap_ready = ($urandom % 4) != 0;
      rst = ($urandom % 250) == 0;
    end
    @(posedge clk); #1;
    rst = 0; win_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
